// File: rtl/digit_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : digit_scan_pkg
// Description : Shared types and helpers for the digit scanner: FSM state
//               type, counter/index width helpers and a one-hot encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package digit_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Widest digit count the one-hot helper can express
  localparam int MAX_DIGITS = 32;

  // Prescale counter width: $clog2(PRESCALE), never below one bit
  function automatic int cnt_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  // Digit index width: $clog2(DIGITS), never below one bit
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  // One-hot vector with bit 'idx' set; callers truncate to their digit count
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage : digit_scan_pkg
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Refresh prescaler. Counts 0..PRESCALE-1 while enabled,
//               clears synchronously, and asserts tick on the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler
  import digit_scan_pkg::*;
#(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = cnt_width(PRESCALE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // Terminal count is only meaningful while the counter is running
  assign tick = en && (cnt == LAST);

  // Free-running modulo-PRESCALE counter with clear taking priority
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/digit_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : digit_scan_mux
// Description : Time-multiplexed N-digit scanner. Snapshots the digit bus and
//               blank mask once per frame, rotates a one-hot digit select and
//               drives the selected nibble to the segment decoder.
//               Optional macro LEAD_ZERO_BLANK_EN: auto-darkens leading zero
//               digits (digit 0 is always lit unless masked).
// Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_mux
  import digit_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int NIB_W    = 4,
  parameter int PRESCALE = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [DIGITS*NIB_W-1:0] in,
  input  logic [DIGITS-1:0]       blank_mask,
  output logic [DIGITS-1:0]       select,
  output logic [NIB_W-1:0]        OUT,
  output logic                    frame_tick
);

  localparam int               IDX_W    = idx_width(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [DIGITS*NIB_W-1:0] snapshot, snap_n;
  logic [DIGITS-1:0]       mask_q, mask_n;
  logic                    load;
  logic                    ft_n;
  logic                    adv_tick;
  logic [DIGITS-1:0]       lz;
  logic [DIGITS-1:0]       sel_n;
  logic [NIB_W-1:0]        nib_n;

  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == SCAN && en),
    .clr   (state != SCAN || !en),
    .tick  (adv_tick)
  );

  // Next-state: frame start, digit advance with snapshot reload at the wrap
  always_comb begin
    state_n = state;
    idx_n   = idx;
    snap_n  = snapshot;
    mask_n  = mask_q;
    load    = 1'b0;
    ft_n    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = SCAN;
          idx_n   = '0;
          snap_n  = in;
          mask_n  = blank_mask;
          load    = 1'b1;
          ft_n    = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (adv_tick) begin
          load = 1'b1;
          if (idx == LAST_IDX) begin
            idx_n  = '0;
            snap_n = in;
            mask_n = blank_mask;
            ft_n   = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic zero_run;

  // Digit k>=1 is a leading zero when it and every higher digit are zero
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (snap_n[k*NIB_W +: NIB_W] == '0);
      lz[k]    = zero_run;
    end
  end
`else
  assign lz = '0;
`endif

  // Outputs are derived from the post-edge index and snapshot
  assign sel_n = DIGITS'(onehot(32'(idx_n))) & ~(mask_n | lz);
  assign nib_n = snap_n[idx_n*NIB_W +: NIB_W];

  // State, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      snapshot   <= '0;
      mask_q     <= '0;
      select     <= '0;
      OUT        <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      snapshot   <= snap_n;
      mask_q     <= mask_n;
      frame_tick <= ft_n;
      if (load) begin
        select <= sel_n;
        OUT    <= nib_n;
      end else if (state_n == IDLE) begin
        select <= '0;
        OUT    <= '0;
      end
    end
  end

endmodule : digit_scan_mux
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_scan_mux
// Description : Self-checking bench for digit_scan_mux (DIGITS=4, NIB_W=4,
//               PRESCALE=3). Frame-position reference model plus directed
//               literal checks, followed by randomized stimulus.
//               Honours LEAD_ZERO_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_mux;

  localparam int DIGITS   = 4;
  localparam int NIB_W    = 4;
  localparam int PRESCALE = 3;
  localparam int FRAME    = DIGITS * PRESCALE;
`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic [DIGITS*NIB_W-1:0] in_bus = '0;
  logic [DIGITS-1:0]       blank = '0;
  logic [DIGITS-1:0]       select;
  logic [NIB_W-1:0]        out_nib;
  logic                    frame_tick;

  always #5 clk = ~clk;

  digit_scan_mux #(
    .DIGITS   (DIGITS),
    .NIB_W    (NIB_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in         (in_bus),
    .blank_mask (blank),
    .select     (select),
    .OUT        (out_nib),
    .frame_tick (frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: scanning flag, position within the frame, frame snapshot
  bit                      armed = 1'b0;
  bit                      m_run = 1'b0;
  int                      m_t   = 0;
  logic [DIGITS*NIB_W-1:0] m_snap = '0;
  logic [DIGITS-1:0]       m_mask = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 1'b0;
      armed = 1'b1;
    end else if (!m_run) begin
      if (en) begin
        m_run  = 1'b1;
        m_t    = 0;
        m_snap = in_bus;
        m_mask = blank;
      end
    end else if (!en) begin
      m_run = 1'b0;
    end else begin
      m_t = (m_t + 1) % FRAME;
      if (m_t == 0) begin
        m_snap = in_bus;
        m_mask = blank;
      end
    end
  end

  function automatic bit model_dark(input int d);
    bit dark;
    dark = m_mask[d];
    if (LZ && d >= 1 && (m_snap >> (d * NIB_W)) == 0) dark = 1'b1;
    return dark;
  endfunction

  // Compare every cycle on the falling edge once reset has been applied
  always @(negedge clk) begin
    if (armed) begin
      int d;
      int e_sel;
      int e_out;
      int e_ft;
      d     = m_t / PRESCALE;
      e_sel = 0;
      e_out = 0;
      e_ft  = 0;
      if (m_run) begin
        e_out = int'((m_snap >> (d * NIB_W)) & 16'hF);
        e_sel = model_dark(d) ? 0 : (1 << d);
        e_ft  = (m_t == 0) ? 1 : 0;
      end
      check("model_select", 32'(select), 32'(e_sel));
      check("model_out", 32'(out_nib), 32'(e_out));
      check("model_frame_tick", 32'(frame_tick), 32'(e_ft));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [3:0] s, input logic [3:0] o, input logic f);
    check({name, "_select"}, 32'(select), 32'(s));
    check({name, "_out"}, 32'(out_nib), 32'(o));
    check({name, "_ft"}, 32'(frame_tick), 32'(f));
  endtask

  initial begin
    logic [3:0] exp_nib [4];
    exp_nib = '{4'd1, 4'd2, 4'd3, 4'd4};

    // Reset then idle
    rst_n = 1'b0; en = 1'b0;
    tick(); tick();
    lit("reset", 4'b0000, 4'd0, 1'b0);
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      lit("idle", 4'b0000, 4'd0, 1'b0);
    end

    // Basic scan of one frame
    in_bus = 16'h4321; blank = '0; en = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      lit("scan", 4'(1 << (i / PRESCALE)), exp_nib[i / PRESCALE], (i == 0));
    end
    tick();
    lit("wrap", 4'b0001, 4'd1, 1'b1);

    // Input change mid-frame must not tear the display
    repeat (3) tick();
    in_bus = 16'h8765;
    tick();          lit("tear_d1", 4'b0010, 4'd2, 1'b0);
    repeat (2) tick(); lit("tear_d2", 4'b0100, 4'd3, 1'b0);
    repeat (3) tick(); lit("tear_d3", 4'b1000, 4'd4, 1'b0);
    repeat (3) tick(); lit("new_frame", 4'b0001, 4'd5, 1'b1);

    // Mask takes effect only from the next frame
    blank = 4'b0100;
    repeat (6) tick(); lit("mask_pending", 4'b0100, 4'd7, 1'b0);
    repeat (6) tick();
    repeat (6) tick(); lit("mask_d2a", 4'b0000, 4'd7, 1'b0);
    tick();          lit("mask_d2b", 4'b0000, 4'd7, 1'b0);
    tick();          lit("mask_d2c", 4'b0000, 4'd7, 1'b0);
    tick();          lit("mask_d3", 4'b1000, 4'd8, 1'b0);
    blank = '0;
    repeat (3) tick();

    // Enable drop mid-scan, then restart with a fresh snapshot
    repeat (6) tick(); lit("pre_drop", 4'b0100, 4'd7, 1'b0);
    en = 1'b0;
    tick();          lit("drop", 4'b0000, 4'd0, 1'b0);
    in_bus = 16'h1234; en = 1'b1;
    tick();          lit("restart", 4'b0001, 4'd4, 1'b1);

    // Reset mid-scan with enable still high
    repeat (6) tick(); lit("pre_rst", 4'b0100, 4'd2, 1'b0);
    rst_n = 1'b0;
    tick();          lit("rst_mid", 4'b0000, 4'd0, 1'b0);
    rst_n = 1'b1;
    tick();          lit("rst_restart", 4'b0001, 4'd4, 1'b1);

    // Leading-zero behaviour (build dependent)
    en = 1'b0; in_bus = 16'h0050;
    tick();
    en = 1'b1;
    tick();            lit("lz_d0", 4'b0001, 4'd0, 1'b1);
    repeat (3) tick(); lit("lz_d1", 4'b0010, 4'd5, 1'b0);
    repeat (3) tick(); lit("lz_d2", LZ ? 4'b0000 : 4'b0100, 4'd0, 1'b0);
    in_bus = 16'h0000;
    repeat (3) tick(); lit("lz_d3", LZ ? 4'b0000 : 4'b1000, 4'd0, 1'b0);
    repeat (3) tick(); lit("lz0_d0", 4'b0001, 4'd0, 1'b1);
    repeat (3) tick(); lit("lz0_d1", LZ ? 4'b0000 : 4'b0010, 4'd0, 1'b0);

    // Randomized traffic checked by the model
    repeat (600) begin
      rst_n = ($urandom_range(99) != 0);
      en    = ($urandom_range(24) != 0);
      if ($urandom_range(3) == 0) in_bus = 16'($urandom);
      if ($urandom_range(9) == 0) blank  = 4'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_digit_scan_mux
`default_nettype wire
